video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Generates the raster scan that sprite and picture blocks consume: hcount, vcount, hsync, vsync and blank.
- Pixel blocks take hcount/vcount and return a pixel one or more cycles later. This block supplies matching delayed syncs and blank so those pixels line up at the DAC/VGA output.
- Defaults target 1024x768 at 60 Hz on the 65 MHz pixel clock.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync pulse width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- PIPE_DELAY, 1, cycles of delay on the *_d outputs; legal range 1..4

Ports:
- pixel_clk  in  1  pixel clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  pixel clock enable; counters and pipeline advance only when high
- hcount  out  11  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync aligned to hcount, active low
- vsync  out  1  vertical sync aligned to vcount, active low
- blank  out  1  high outside the active area, aligned to hcount/vcount
- hsync_d  out  1  hsync delayed PIPE_DELAY ce-cycles
- vsync_d  out  1  vsync delayed PIPE_DELAY ce-cycles
- blank_d  out  1  blank delayed PIPE_DELAY ce-cycles
- frame_start  out  1  one-ce-cycle pulse when counters wrap to (0,0)
- frame_count  out  8  frames completed, wraps 255 -> 0

Behaviour:
- Clocking and reset (fixed): single clock pixel_clk; reset_n is asynchronous and active-low.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
- Reset values:
  - hcount=0, vcount=0, hsync=1, vsync=1, blank=0
  - hsync_d=1, vsync_d=1, blank_d=1 (entire pipeline filled with inactive values)
  - frame_start=0, frame_count=0
- Counting, on a rising edge with ce=1:
  - hcount increments; when hcount==H_TOTAL-1 it becomes 0 and vcount increments.
  - When vcount==V_TOTAL-1 and hcount==H_TOTAL-1, both counters become 0.
- ce=0: every register holds, including the *_d pipeline and frame_start. A pulse therefore lasts exactly one ce-qualified cycle and is extended through any ce=0 cycles that follow it.
- All outputs are registered. Sync/blank values are computed from the next counter values, so at every edge they describe the hcount/vcount presented in the same cycle.
- hsync=0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (1048..1183).
- vsync=0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (771..776). vsync changes only with the vcount update.
- blank=1 iff hcount >= H_ACTIVE or vcount >= V_ACTIVE.
- *_d outputs: shift register of depth PIPE_DELAY, advanced on ce. PIPE_DELAY=1 matches the one-cycle ROM latency of picture blocks.
- frame_start = 1 in the cycle where counters equal (0,0) as the result of a wrap from (H_TOTAL-1, V_TOTAL-1). It is not asserted on the first frame after reset.
- frame_count increments modulo 256 in the same edge that raises frame_start.
- Width rules:
  - Comparisons are unsigned at 11 bits (horizontal) and 10 bits (vertical).
  - Parameter sums must fit: H_TOTAL <= 2048, V_TOTAL <= 1024. Violations trigger an elaboration-time $error.
- Reset mid-frame: all registers return to their reset values immediately, independent of the clock. Counting restarts from (0,0) on the first ce edge after reset_n rises.

Decomposition:
- Shared package video_pkg holds:
  - the XGA 1024x768 timing constants (shared with the picture/sprite blocks and the top level)
  - HCOUNT_W=11 and VCOUNT_W=10
- One sub-module, sync_delay_line: a parameterised-depth, ce-gated shift register with a reset value input. It is instantiated three times, for hsync, vsync and blank.
- The counter and decode logic stay in video_timing_gen.

Test Plan:
- Reset then ce=1 constant for 1344 cycles -> hcount steps 0..1343 then 0; vcount steps 0->1 on the wrap; blank rises at hcount=1024.
- Same run, hsync -> low exactly for hcount 1048..1183 (136 cycles); hsync_d goes low one cycle later with PIPE_DELAY=1, four cycles later with PIPE_DELAY=4.
- Run a full frame (1344*806 = 1083264 ce-cycles) -> vsync low for vcount 771..776; frame_start pulses once at (0,0) after the wrap; frame_count 0->1; no frame_start at the first (0,0) after reset.
- ce toggling 1,0,1,0 -> hcount advances only on ce=1 edges; a frame_start pulse is held through the following ce=0 cycle; *_d pipeline does not shift while ce=0.
- Assert reset_n low asynchronously at hcount=500, vcount=300 -> all outputs take reset values before the next clock edge; after release, the count resumes from 0,0.
- Run 256 frames -> frame_count wraps 255->0 on the 256th frame_start.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video timing package.
// Holds the XGA 1024x768 @ 60 Hz raster constants used by the timing
// generator and by the picture/sprite blocks, plus the counter widths.
package video_pkg;

   // Counter widths: 11 bits covers H_TOTAL up to 2048, 10 bits V_TOTAL up to 1024
   localparam int HCOUNT_W = 11;
   localparam int VCOUNT_W = 10;
   localparam int FCOUNT_W = 8;

   // XGA 1024x768 @ 60 Hz, 65 MHz pixel clock
   localparam int XGA_H_ACTIVE = 1024;
   localparam int XGA_H_FP     = 24;
   localparam int XGA_H_SYNC   = 136;
   localparam int XGA_H_BP     = 160;
   localparam int XGA_V_ACTIVE = 768;
   localparam int XGA_V_FP     = 3;
   localparam int XGA_V_SYNC   = 6;
   localparam int XGA_V_BP     = 29;

endpackage

// File: rtl/sync_delay_line.sv
// Parameterised-depth, clock-enable-gated shift register for 1-bit timing
// signals. The whole chain resets to i_rst_val so that a delayed sync or
// blank reads as inactive until real data has propagated through.
// Ports:
//   i_clk     - clock, rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_ce      - shift enable; chain holds when low
//   i_rst_val - value loaded into every stage on reset (tie to a constant)
//   i_d       - serial input
//   o_q       - output, i_d delayed DEPTH enabled cycles
module sync_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ce,
   input  logic i_rst_val,
   input  logic i_d,
   output logic o_q
);

   logic [DEPTH-1:0] r_sr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr <= {DEPTH{i_rst_val}};
      end else if (i_ce) begin
         r_sr[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) begin
            r_sr[i] <= r_sr[i-1];
         end
      end
   end

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator.
// Produces hcount/vcount plus hsync, vsync and blank aligned to the counters,
// and copies of the syncs/blank delayed PIPE_DELAY enabled cycles so they line
// up with pixels that downstream blocks return a few cycles after the counts.
// Ports:
//   pixel_clk   - pixel clock, rising edge
//   reset_n     - asynchronous active-low reset
//   ce          - pixel clock enable; everything holds while low
//   hcount      - current column, 0..H_TOTAL-1
//   vcount      - current line, 0..V_TOTAL-1
//   hsync/vsync - active-low syncs aligned to hcount/vcount
//   blank       - high outside the active area, aligned to hcount/vcount
//   hsync_d/vsync_d/blank_d - the above delayed PIPE_DELAY ce-cycles
//   frame_start - one ce-cycle pulse when the counters wrap to (0,0)
//   frame_count - completed frames, modulo 256
module video_timing_gen
   import video_pkg::*;
#(
   parameter int H_ACTIVE   = XGA_H_ACTIVE,
   parameter int H_FP       = XGA_H_FP,
   parameter int H_SYNC     = XGA_H_SYNC,
   parameter int H_BP       = XGA_H_BP,
   parameter int V_ACTIVE   = XGA_V_ACTIVE,
   parameter int V_FP       = XGA_V_FP,
   parameter int V_SYNC     = XGA_V_SYNC,
   parameter int V_BP       = XGA_V_BP,
   parameter int PIPE_DELAY = 1
) (
   input  logic                pixel_clk,
   input  logic                reset_n,
   input  logic                ce,
   output logic [HCOUNT_W-1:0] hcount,
   output logic [VCOUNT_W-1:0] vcount,
   output logic                hsync,
   output logic                vsync,
   output logic                blank,
   output logic                hsync_d,
   output logic                vsync_d,
   output logic                blank_d,
   output logic                frame_start,
   output logic [FCOUNT_W-1:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > (1 << HCOUNT_W)) begin : g_h_total_chk
         $error("video_timing_gen: H_TOTAL exceeds hcount range");
      end
      if (V_TOTAL > (1 << VCOUNT_W)) begin : g_v_total_chk
         $error("video_timing_gen: V_TOTAL exceeds vcount range");
      end
      if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_pipe_chk
         $error("video_timing_gen: PIPE_DELAY must be 1..4");
      end
   endgenerate

   // Decode boundaries at counter width so every compare is unsigned
   localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(H_TOTAL - 1);
   localparam logic [HCOUNT_W-1:0] H_VIS    = HCOUNT_W'(H_ACTIVE);
   localparam logic [HCOUNT_W-1:0] HS_BEG   = HCOUNT_W'(H_ACTIVE + H_FP);
   localparam logic [HCOUNT_W-1:0] HS_END   = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(V_TOTAL - 1);
   localparam logic [VCOUNT_W-1:0] V_VIS    = VCOUNT_W'(V_ACTIVE);
   localparam logic [VCOUNT_W-1:0] VS_BEG   = VCOUNT_W'(V_ACTIVE + V_FP);
   localparam logic [VCOUNT_W-1:0] VS_END   = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [HCOUNT_W-1:0] r_hcount;
   logic [VCOUNT_W-1:0] r_vcount;
   logic                r_hsync;
   logic                r_vsync;
   logic                r_blank;
   logic                r_frame_start;
   logic [FCOUNT_W-1:0] r_frame_count;

   logic [HCOUNT_W-1:0] w_hcount_nxt;
   logic [VCOUNT_W-1:0] w_vcount_nxt;
   logic                w_h_last;
   logic                w_v_last;
   logic                w_wrap;
   logic                w_hsync_nxt;
   logic                w_vsync_nxt;
   logic                w_blank_nxt;

   // Syncs and blank are decoded from the next counter values so that the
   // registered versions describe the counts presented in the same cycle.
   always_comb begin
      w_h_last     = (r_hcount == H_LAST);
      w_v_last     = (r_vcount == V_LAST);
      w_wrap       = w_h_last && w_v_last;
      w_hcount_nxt = r_hcount + HCOUNT_W'(1);
      w_vcount_nxt = r_vcount;
      if (w_h_last) begin
         w_hcount_nxt = '0;
         w_vcount_nxt = w_v_last ? '0 : r_vcount + VCOUNT_W'(1);
      end
      w_hsync_nxt = !((w_hcount_nxt >= HS_BEG) && (w_hcount_nxt < HS_END));
      w_vsync_nxt = !((w_vcount_nxt >= VS_BEG) && (w_vcount_nxt < VS_END));
      w_blank_nxt = (w_hcount_nxt >= H_VIS) || (w_vcount_nxt >= V_VIS);
   end

   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hcount      <= '0;
         r_vcount      <= '0;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_blank       <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
      end else if (ce) begin
         r_hcount      <= w_hcount_nxt;
         r_vcount      <= w_vcount_nxt;
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_blank       <= w_blank_nxt;
         // Only a real wrap raises the pulse, so the (0,0) after reset is silent
         r_frame_start <= w_wrap;
         if (w_wrap) begin
            r_frame_count <= r_frame_count + FCOUNT_W'(1);
         end
      end
   end

   // Delayed copies reset to inactive (syncs high, blank high) so the output
   // stays dark until the pipeline holds real samples.
   sync_delay_line #(.DEPTH(PIPE_DELAY)) u_hsync_dl (
      .i_clk     (pixel_clk),
      .i_rst_n   (reset_n),
      .i_ce      (ce),
      .i_rst_val (1'b1),
      .i_d       (r_hsync),
      .o_q       (hsync_d)
   );

   sync_delay_line #(.DEPTH(PIPE_DELAY)) u_vsync_dl (
      .i_clk     (pixel_clk),
      .i_rst_n   (reset_n),
      .i_ce      (ce),
      .i_rst_val (1'b1),
      .i_d       (r_vsync),
      .o_q       (vsync_d)
   );

   sync_delay_line #(.DEPTH(PIPE_DELAY)) u_blank_dl (
      .i_clk     (pixel_clk),
      .i_rst_n   (reset_n),
      .i_ce      (ce),
      .i_rst_val (1'b1),
      .i_d       (r_blank),
      .o_q       (blank_d)
   );

   assign hcount      = r_hcount;
   assign vcount      = r_vcount;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign blank       = r_blank;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen.
// "s" instance: tiny raster (13 x 8, PIPE_DELAY=1) so whole frames and the
// 256-frame wrap fit in a short run. hsync low at h=9..10, vsync low at v=5,
// blank at h>=8 or v>=4, frame = 104 ce-cycles.
// "b" instance: default XGA timing with PIPE_DELAY=4, checked over one line.
module tb_video_timing_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce;

   logic [10:0] s_h, b_h;
   logic [9:0]  s_v, b_v;
   logic        s_hs, s_vs, s_bl, s_hsd, s_vsd, s_bld, s_fs;
   logic        b_hs, b_vs, b_bl, b_hsd, b_vsd, b_bld, b_fs;
   logic [7:0]  s_fc, b_fc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .PIPE_DELAY(1)
   ) u_s (
      .pixel_clk(clk), .reset_n(rst_n), .ce(ce),
      .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs), .blank(s_bl),
      .hsync_d(s_hsd), .vsync_d(s_vsd), .blank_d(s_bld),
      .frame_start(s_fs), .frame_count(s_fc)
   );

   video_timing_gen #(.PIPE_DELAY(4)) u_b (
      .pixel_clk(clk), .reset_n(rst_n), .ce(ce),
      .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs), .blank(b_bl),
      .hsync_d(b_hsd), .vsync_d(b_vsd), .blank_d(b_bld),
      .frame_start(b_fs), .frame_count(b_fc)
   );

   typedef struct {
      int   t;
      int   h;
      int   v;
      logic hs, vs, bl, hsd, vsd, bld, fs;
      int   fc;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_s_reset(input string tag);
      chk({tag, " s_h"}, int'(s_h), 0);
      chk({tag, " s_v"}, int'(s_v), 0);
      chk({tag, " s_hs"}, int'(s_hs), 1);
      chk({tag, " s_vs"}, int'(s_vs), 1);
      chk({tag, " s_bl"}, int'(s_bl), 0);
      chk({tag, " s_hsd"}, int'(s_hsd), 1);
      chk({tag, " s_vsd"}, int'(s_vsd), 1);
      chk({tag, " s_bld"}, int'(s_bld), 1);
      chk({tag, " s_fs"}, int'(s_fs), 0);
      chk({tag, " s_fc"}, int'(s_fc), 0);
   endtask

   task automatic chk_b_reset(input string tag);
      chk({tag, " b_h"}, int'(b_h), 0);
      chk({tag, " b_v"}, int'(b_v), 0);
      chk({tag, " b_sync"}, int'({b_hs, b_vs, b_bl}), 3'b110);
      chk({tag, " b_dly"}, int'({b_hsd, b_vsd, b_bld}), 3'b111);
      chk({tag, " b_frame"}, int'({b_fs, b_fc}), 0);
   endtask

   initial begin
      int vi;
      int b_first_bl, b_hs_cnt, b_hs_first, b_hs_last, b_hsd_cnt, b_hsd_first, b_fs_cnt;
      int s_first_fs;
      int n, pulses, pulse_t;
      int exp_h;
      logic [7:0] fc_prev;
      logic [7:0] fc_255, fc_256;

      //          t    h   v  hs vs bl hsd vsd bld fs fc
      vecs[0]  = '{  0,  0, 0, 1, 1, 0, 1, 1, 1, 0, 0};
      vecs[1]  = '{  7,  7, 0, 1, 1, 0, 1, 1, 0, 0, 0};
      vecs[2]  = '{  8,  8, 0, 1, 1, 1, 1, 1, 0, 0, 0};
      vecs[3]  = '{  9,  9, 0, 0, 1, 1, 1, 1, 1, 0, 0};
      vecs[4]  = '{ 10, 10, 0, 0, 1, 1, 0, 1, 1, 0, 0};
      vecs[5]  = '{ 11, 11, 0, 1, 1, 1, 0, 1, 1, 0, 0};
      vecs[6]  = '{ 12, 12, 0, 1, 1, 1, 1, 1, 1, 0, 0};
      vecs[7]  = '{ 13,  0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
      vecs[8]  = '{ 52,  0, 4, 1, 1, 1, 1, 1, 1, 0, 0};
      vecs[9]  = '{ 65,  0, 5, 1, 0, 1, 1, 1, 1, 0, 0};
      vecs[10] = '{ 77, 12, 5, 1, 0, 1, 1, 0, 1, 0, 0};
      vecs[11] = '{ 78,  0, 6, 1, 1, 1, 1, 0, 1, 0, 0};
      vecs[12] = '{103, 12, 7, 1, 1, 1, 1, 1, 1, 0, 0};
      vecs[13] = '{104,  0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
      vecs[14] = '{105,  1, 0, 1, 1, 0, 1, 1, 0, 0, 1};

      // ---- reset state ----
      rst_n = 1'b0;
      ce    = 1'b0;
      step();
      ce = 1'b1;
      step();
      chk_s_reset("rst");
      chk_b_reset("rst");

      // ---- free run: table on small raster, event capture on XGA line ----
      rst_n = 1'b1;
      b_first_bl = -1; b_hs_cnt = 0; b_hs_first = -1; b_hs_last = -1;
      b_hsd_cnt = 0; b_hsd_first = -1; b_fs_cnt = 0; s_first_fs = -1;
      vi = 0;
      for (int t = 0; t <= 1400; t++) begin
         if (t > 0) step();
         if (vi < 15 && vecs[vi].t == t) begin
            chk($sformatf("v%0d h", vi), int'(s_h), vecs[vi].h);
            chk($sformatf("v%0d v", vi), int'(s_v), vecs[vi].v);
            chk($sformatf("v%0d hs/vs/bl", vi), int'({s_hs, s_vs, s_bl}),
                int'({vecs[vi].hs, vecs[vi].vs, vecs[vi].bl}));
            chk($sformatf("v%0d hsd/vsd/bld", vi), int'({s_hsd, s_vsd, s_bld}),
                int'({vecs[vi].hsd, vecs[vi].vsd, vecs[vi].bld}));
            chk($sformatf("v%0d fs", vi), int'(s_fs), int'(vecs[vi].fs));
            chk($sformatf("v%0d fc", vi), int'(s_fc), vecs[vi].fc);
            vi++;
         end
         if (s_fs && s_first_fs < 0) s_first_fs = t;
         if (b_bl && b_first_bl < 0) b_first_bl = t;
         if (!b_hs) begin
            b_hs_cnt++;
            if (b_hs_first < 0) b_hs_first = t;
            b_hs_last = t;
         end
         if (!b_hsd) begin
            b_hsd_cnt++;
            if (b_hsd_first < 0) b_hsd_first = t;
         end
         if (b_fs) b_fs_cnt++;
         if (t == 3) chk("b_bld t3", int'(b_bld), 1);
         if (t == 4) chk("b_bld t4", int'(b_bld), 0);
         if (t == 1343) begin
            chk("b_h end of line", int'(b_h), 1343);
            chk("b_v end of line", int'(b_v), 0);
         end
         if (t == 1344) begin
            chk("b_h wrap", int'(b_h), 0);
            chk("b_v wrap", int'(b_v), 1);
         end
      end
      chk("table vectors applied", vi, 15);
      chk("s first frame_start t", s_first_fs, 104);
      chk("b blank rise t", b_first_bl, 1024);
      chk("b hsync low cycles", b_hs_cnt, 136);
      chk("b hsync first low", b_hs_first, 1048);
      chk("b hsync last low", b_hs_last, 1183);
      chk("b hsync_d low cycles", b_hsd_cnt, 136);
      chk("b hsync_d first low", b_hsd_first, 1052);
      chk("b no frame_start in line", b_fs_cnt, 0);

      // ---- ce toggling around a frame wrap ----
      n = 0;
      while (!(s_h == 11'd12 && s_v == 10'd7) && n < 200) begin
         step();
         n++;
      end
      chk("reach end of frame", int'(s_h == 11'd12 && s_v == 10'd7), 1);
      fc_prev = s_fc;
      step();
      chk("ce wrap fs", int'(s_fs), 1);
      chk("ce wrap h/v", int'({s_h, s_v}), 0);
      chk("ce wrap fc", int'(s_fc), int'(fc_prev + 8'd1));
      ce = 1'b0;
      step();
      chk("ce0 fs held", int'(s_fs), 1);
      chk("ce0 h held", int'(s_h), 0);
      chk("ce0 fc held", int'(s_fc), int'(fc_prev + 8'd1));
      ce = 1'b1;
      step();
      chk("ce1 fs drop", int'(s_fs), 0);
      chk("ce1 h", int'(s_h), 1);
      exp_h = 1;
      for (int k = 0; k < 7; k++) begin
         ce = 1'b0;
         step();
         chk($sformatf("tog%0d ce0 h", k), int'(s_h), exp_h);
         ce = 1'b1;
         step();
         exp_h++;
         chk($sformatf("tog%0d ce1 h", k), int'(s_h), exp_h);
      end
      chk("h8 blank", int'(s_bl), 1);
      chk("h8 blank_d", int'(s_bld), 0);
      ce = 1'b0;
      step();
      chk("ce0 blank_d held", int'(s_bld), 0);
      ce = 1'b1;
      step();
      chk("ce1 blank_d shift", int'(s_bld), 1);
      chk("ce1 h9", int'(s_h), 9);

      // ---- asynchronous reset mid-frame ----
      n = 0;
      while (!(s_h == 11'd5 && s_v == 10'd3) && n < 200) begin
         step();
         n++;
      end
      chk("reach h5 v3", int'(s_h == 11'd5 && s_v == 10'd3), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_s_reset("async");
      chk_b_reset("async");
      step();
      chk("held in reset h", int'(s_h), 0);
      rst_n = 1'b1;
      #1;
      chk("after release h", int'(s_h), 0);
      step();
      chk("first edge h", int'(s_h), 1);
      chk("first edge v", int'(s_v), 0);
      chk("first edge hsd", int'(s_hsd), 1);
      chk("first edge fc", int'(s_fc), 0);

      // ---- 256 frames: frame_count wraps on the 256th pulse ----
      pulses = 0; pulse_t = -1; fc_255 = 8'hxx; fc_256 = 8'hxx;
      n = 1;
      while (pulses < 256 && n < 27000) begin
         step();
         n++;
         if (s_fs) begin
            pulses++;
            if (pulses == 1) pulse_t = n;
            if (pulses == 255) fc_255 = s_fc;
            if (pulses == 256) begin
               fc_256 = s_fc;
               chk("256th pulse t", n, 256 * 104);
            end
         end
      end
      chk("pulses seen", pulses, 256);
      chk("first pulse after reset t", pulse_t, 104);
      chk("fc at 255th", int'(fc_255), 255);
      chk("fc at 256th", int'(fc_256), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
